// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 LSB first, 16x oversampling with a 2-of-3
// majority vote at ticks 7/8/9 of every bit.
// Optional macro UART_RX_PARITY_EN: 8E1 frames with a PARITY state and
// parity_err reporting; without it parity_err is tied low.
module uart_rx #(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_rx,
  output logic [7:0] data,
  output logic       data_strobe,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int unsigned DIV   = (CLK_HZ + BAUD * (OVERSAMPLE / 2)) / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t           state;
  logic             rx_q1;
  logic             rx_s;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       tick_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic [1:0]       samp;
  logic             tick;
  logic             decide;
  logic             wrap;
  logic             maj;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
`else
  assign parity_err = 1'b0;
`endif

  // Tick 9 is reached on the tick leaving count 8; the next bit starts on 15->0.
  assign tick   = (div_cnt == DIV_LAST);
  assign decide = tick && (tick_cnt == 4'd8);
  assign wrap   = tick && (tick_cnt == 4'd15);
  assign maj    = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

  // Two-flop synchronizer for the asynchronous line, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= serial_rx;
      rx_s  <= rx_q1;
    end
  end

  // Oversampling divider, bit sampling and frame state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      div_cnt     <= '0;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      samp        <= '0;
      data        <= '0;
      data_strobe <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
      parity_err  <= 1'b0;
`endif
    end else begin
      data_strobe <= 1'b0;
      frame_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) begin
        tick_cnt <= tick_cnt + 4'd1;
        if (tick_cnt == 4'd6) samp[0] <= rx_s;
        if (tick_cnt == 4'd7) samp[1] <= rx_s;
      end

      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            busy     <= 1'b1;
            div_cnt  <= '0;
            tick_cnt <= '0;
          end
        end
        START: begin
          if (decide && maj) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (wrap) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (decide) shreg <= {maj, shreg[7:1]};
          if (wrap) begin
            bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == 3'd7) state <= PARITY;
`else
            if (bit_cnt == 3'd7) state <= STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (decide) par_bit <= maj;
          if (wrap) state <= STOP;
        end
`endif
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (decide) begin
            if (!maj) begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (^{shreg, par_bit}) begin
                parity_err <= 1'b1;
              end else begin
                data        <= shreg;
                data_strobe <= 1'b1;
              end
`else
              data        <= shreg;
              data_strobe <= 1'b1;
`endif
            end
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized self-checking bench for uart_rx. Runs the DUT with
// CLK_HZ=12 MHz and BAUD=75000 so one bit is 160 clk and frames stay short.
// Honours UART_RX_PARITY_EN when the build defines it.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 12000000;
  localparam int unsigned BAUD   = 75000;
  localparam int unsigned DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned BITC   = DIV * 16;
  localparam int unsigned TOL    = DIV + 4;
`ifdef UART_RX_PARITY_EN
  localparam bit          HAS_PAR = 1'b1;
  localparam int unsigned NPRE    = 10;
`else
  localparam bit          HAS_PAR = 1'b0;
  localparam int unsigned NPRE    = 9;
`endif

  typedef enum int {EV_STROBE, EV_FRAME, EV_PARITY} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] val;
    longint     lo;
    longint     hi;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       serial_rx = 1'b1;
  logic [7:0] data;
  logic       data_strobe;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int         checks = 0;
  int         failures = 0;
  longint     cyc = 0;
  bit         run_chk = 1'b0;
  ev_t        expq[$];
  longint     strobe_t[$];
  int         fe_count = 0;
  int         pe_count = 0;
  logic [7:0] model_data = 8'h00;

  ev_t        cur;
  ev_kind_t   got;
  int         npulse;
  longint     fall0;
  longint     gfall;
  logic [7:0] tmp;
  logic [7:0] rb;
  int unsigned rbc;
  int unsigned rgap;
  bit         rstop;
  bit         rpar;

  uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .serial_rx  (serial_rx),
    .data       (data),
    .data_strobe(data_strobe),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d..%0d (cyc %0d)", name, act, lo, hi, cyc);
    end
  endtask

  task automatic wait_cyc(input int unsigned n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // One frame on the line; the expected outcome and its time window are queued
  // from the frame contents: decision 9.5 bit times (10.5 with parity) after
  // the start edge plus the 2-clk synchronizer, within one tick.
  task automatic send_frame(input logic [7:0] b, input int unsigned bitc,
                            input bit stop_ok, input bit par_ok);
    ev_t    e;
    longint fall;
    fall   = cyc;
    e.val  = b;
    e.kind = !stop_ok ? EV_FRAME : ((par_ok || !HAS_PAR) ? EV_STROBE : EV_PARITY);
    e.lo   = fall + 2 + NPRE * BITC + BITC / 2 - TOL;
    e.hi   = fall + 2 + NPRE * BITC + BITC / 2 + TOL;
    expq.push_back(e);
    serial_rx = 1'b0;
    wait_cyc(bitc);
    for (int i = 0; i < 8; i++) begin
      serial_rx = b[i];
      if (i == 2) chk("busy_mid_frame", busy, 1);
      wait_cyc(bitc);
    end
    if (HAS_PAR) begin
      serial_rx = (^b) ^ !par_ok;
      wait_cyc(bitc);
    end
    serial_rx = stop_ok;
    wait_cyc(bitc);
  endtask

  // Compare process: every pulse must match the next queued expectation in
  // kind, time window and value; data must hold the last good byte.
  always @(negedge clk) begin
    if (run_chk && !reset) begin
      npulse = int'(data_strobe) + int'(frame_err) + int'(parity_err);
      chk("pulse_exclusive", npulse <= 1, 1);
      if (npulse != 0) begin
        got = data_strobe ? EV_STROBE : (frame_err ? EV_FRAME : EV_PARITY);
        if (frame_err) fe_count++;
        if (parity_err) pe_count++;
        if (expq.size() == 0) begin
          chk("unexpected_pulse", got, -1);
        end else begin
          cur = expq.pop_front();
          chk("event_kind", got, cur.kind);
          chk_range("event_time", cyc, cur.lo, cur.hi);
          if (got == EV_STROBE) begin
            model_data = cur.val;
            strobe_t.push_back(cyc);
          end
        end
      end
      if (expq.size() > 0 && cyc > expq[0].hi) begin
        chk("event_missing", expq[0].kind, -1);
        void'(expq.pop_front());
      end
      chk("data_hold", data, model_data);
    end
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish (cyc %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    serial_rx = 1'b1;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(2);
    chk("reset_data", data, 8'h00);
    chk("reset_strobe", data_strobe, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_parity_err", parity_err, 0);
    chk("reset_busy", busy, 0);
    run_chk = 1'b1;
    wait_cyc(20);

    // Single byte, nominal bit length.
    fall0 = cyc;
    send_frame(8'h41, BITC, 1'b1, 1'b1);
    wait_cyc(50);
    chk("first_data", data, 8'h41);
    chk("first_strobe_count", strobe_t.size(), 1);
    chk("first_busy_after", busy, 0);
    if (strobe_t.size() >= 1)
      chk_range("first_latency", strobe_t[0] - fall0,
                HAS_PAR ? 1682 - 14 : 1522 - 14, HAS_PAR ? 1682 + 14 : 1522 + 14);

    // Back-to-back frames, no idle bits between them.
    send_frame(8'h00, BITC, 1'b1, 1'b1);
    send_frame(8'hFF, BITC, 1'b1, 1'b1);
    wait_cyc(100);
    chk("b2b_data", data, 8'hFF);
    chk("b2b_strobe_count", strobe_t.size(), 3);
    if (strobe_t.size() >= 3)
      chk_range("b2b_spacing", strobe_t[2] - strobe_t[1],
                (HAS_PAR ? 11 : 10) * BITC - TOL, (HAS_PAR ? 11 : 10) * BITC + TOL);

    // Short low glitch: false start, no pulses.
    gfall = cyc;
    serial_rx = 1'b0;
    wait_cyc(20);
    chk("glitch_busy_high", busy, 1);
    wait_cyc(20);
    serial_rx = 1'b1;
    wait_cyc(120 - 40);
    chk("glitch_busy_low", busy, 0);
    chk("glitch_elapsed", cyc - gfall, 120);
    chk("glitch_strobe_count", strobe_t.size(), 3);
    wait_cyc(200);

    // Bad stop bit followed by a held-low break.
    send_frame(8'h55, BITC, 1'b0, 1'b1);
    wait_cyc(500);
    chk("break_busy_held", busy, 1);
    serial_rx = 1'b1;
    wait_cyc(10);
    chk("break_busy_released", busy, 0);
    chk("break_frame_err_count", fe_count, 1);
    chk("break_data_kept", data, 8'hFF);
    chk("break_strobe_count", strobe_t.size(), 3);
    wait_cyc(50);

    // Reset in the middle of a frame, after bit 3.
    tmp = 8'hA5;
    serial_rx = 1'b0;
    wait_cyc(BITC);
    for (int i = 0; i < 4; i++) begin
      serial_rx = tmp[i];
      wait_cyc(BITC);
    end
    reset = 1'b1;
    serial_rx = 1'b1;
    expq.delete();
    model_data = 8'h00;
    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(3);
    chk("midreset_data", data, 8'h00);
    chk("midreset_busy", busy, 0);
    chk("midreset_strobe", data_strobe, 0);
    chk("midreset_frame_err", frame_err, 0);
    chk("midreset_parity_err", parity_err, 0);
    wait_cyc(20);
    send_frame(8'h3C, BITC, 1'b1, 1'b1);
    wait_cyc(50);
    chk("after_reset_data", data, 8'h3C);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, BITC, 1'b1, 1'b1);
    wait_cyc(50);
    chk("parity_good_data", data, 8'h07);
    send_frame(8'h07, BITC, 1'b1, 1'b0);
    wait_cyc(50);
    chk("parity_bad_count", pe_count, 1);
    chk("parity_bad_data_kept", data, 8'h07);
`endif

    // Random frames: data, bit length within +-2.5%, gaps, bad stop bits.
    for (int f = 0; f < 20; f++) begin
      rb    = 8'($urandom);
      rbc   = $urandom_range(156, 164);
      rstop = ($urandom_range(0, 4) != 0);
      rpar  = ($urandom_range(0, 3) != 0);
      send_frame(rb, rbc, rstop, rpar);
      if (!rstop) begin
        wait_cyc($urandom_range(1, 400));
        serial_rx = 1'b1;
        wait_cyc(10);
      end
      rgap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 300);
      wait_cyc(rgap);
    end

    wait_cyc(2 * BITC);
    chk("queue_drained", expq.size(), 0);
    chk("final_busy", busy, 0);
    run_chk = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
